// File: rtl/burst_address_arbiter_pkg.sv
// rtl/burst_address_arbiter_pkg.sv - shared types and helpers for the burst address arbiter
// Purpose: FSM state enum plus the clog2 and one_hot helpers used by the
//          arbiter, its interface and the round-robin picker.
// Ports:   none (package).
package addr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Widest requester vector supported; one_hot() returns this width and
  // callers size-cast the result down to NUM_REQ.
  localparam int MAX_REQ = 16;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic logic [MAX_REQ-1:0] one_hot(input int idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/burst_address_arbiter_if.sv
// rtl/burst_address_arbiter_if.sv - request/grant and address-stream bundle of the arbiter
// Purpose: groups the requester handshake and the shared address stream.
// Ports:   req/enable driven by the requester side (master modport);
//          grant, grant_id, busy, address, nd, lastData, done driven by
//          the arbiter (slave modport).
interface burst_address_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int bitwidth = 5,
  parameter int IDW      = addr_arb_pkg::clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]  req;
  logic                enable;
  logic [NUM_REQ-1:0]  grant;
  logic [IDW-1:0]      grant_id;
  logic                busy;
  logic [bitwidth-1:0] address;
  logic                nd;
  logic                lastData;
  logic [NUM_REQ-1:0]  done;

  modport master (
    output req, enable,
    input  grant, grant_id, busy, address, nd, lastData, done
  );

  modport slave (
    input  req, enable,
    output grant, grant_id, busy, address, nd, lastData, done
  );

endinterface

// File: rtl/burst_address_arbiter_rr_pick.sv
// rtl/burst_address_arbiter_rr_pick.sv - combinational round-robin winner search
// Purpose: finds the first set request bit starting at last+1 with wrap-around.
// Ports:   req   in  NUM_REQ - request vector
//          last  in  IDW     - index of the most recent winner
//          found out 1       - at least one request is set
//          idx   out IDW     - winning index (equals last when nothing found)
module rr_pick
  import addr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last,
  output logic               found,
  output logic [IDW-1:0]     idx
);

  // base < NUM_REQ and off <= NUM_REQ, so one conditional subtract wraps.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  // Scan from the farthest offset down to the nearest so the nearest set bit
  // after last overwrites the others; offset NUM_REQ is last itself, i.e.
  // the previous winner has lowest priority.
  always_comb begin
    found = 1'b0;
    idx   = last;
    for (int off = NUM_REQ; off >= 1; off--) begin
      if (req[wrap_idx(last, off)]) begin
        found = 1'b1;
        idx   = wrap_idx(last, off);
      end
    end
  end

endmodule

// File: rtl/burst_address_arbiter.sv
// rtl/burst_address_arbiter.sv - round-robin owner of one shared sequential address burst
// Purpose: grants the shared address stream to one requester at a time and
//          issues addresses 0..MaxAddress-1 to it, one per enabled cycle.
// Ports:   clock in 1 - rising-edge clock
//          reset in 1 - synchronous, active-high
//          bus   slave modport of burst_address_arbiter_if
//                (req/enable in; grant, grant_id, busy, address, nd,
//                 lastData, done out - all registered)
module burst_address_arbiter
  import addr_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int MaxAddress = 20,
  parameter int bitwidth   = 5,
  parameter int IDW        = clog2(NUM_REQ)
) (
  input logic                    clock,
  input logic                    reset,
  burst_address_arbiter_if.slave bus
);

  localparam logic [bitwidth-1:0] LAST_ADDR = bitwidth'(MaxAddress - 1);
  localparam logic [IDW-1:0]      LAST_INIT = IDW'(NUM_REQ - 1);

  state_t              state;
  logic [bitwidth-1:0] cnt;
  logic [IDW-1:0]      last;

  logic [NUM_REQ-1:0]  grant_q;
  logic [IDW-1:0]      grant_id_q;
  logic                busy_q;
  logic [bitwidth-1:0] address_q;
  logic                nd_q;
  logic                last_data_q;
  logic [NUM_REQ-1:0]  done_q;

  logic                pick_found;
  logic [IDW-1:0]      pick_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req   (bus.req),
    .last  (last),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      last        <= LAST_INIT;
      grant_q     <= '0;
      grant_id_q  <= '0;
      busy_q      <= 1'b0;
      address_q   <= '0;
      nd_q        <= 1'b0;
      last_data_q <= 1'b0;
      done_q      <= '0;
    end else begin
      nd_q        <= 1'b0;
      last_data_q <= 1'b0;
      done_q      <= '0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_q    <= NUM_REQ'(one_hot(int'(pick_idx)));
            grant_id_q <= pick_idx;
            last       <= pick_idx;
            busy_q     <= 1'b1;
            cnt        <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          // lastData is only ever high for the one cycle after the final
          // beat, so it doubles as the burst-complete marker.
          if (last_data_q) begin
            state   <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= grant_q;
          end else if (bus.enable) begin
            address_q <= cnt;
            nd_q      <= 1'b1;
            if (cnt == LAST_ADDR) begin
              last_data_q <= 1'b1;
              cnt         <= '0;
            end else begin
              cnt <= cnt + bitwidth'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = busy_q;
  assign bus.address  = address_q;
  assign bus.nd       = nd_q;
  assign bus.lastData = last_data_q;
  assign bus.done     = done_q;

endmodule
